// File: rtl/fwd_hazard_ctrl.sv
// Operand-B forwarding select and load-use stall control for the EX-stage operand-B mux.
// Tracks destination info of the EX and MEM instructions and resolves RAW hazards seen in ID.
module fwd_hazard_ctrl #(
  parameter int unsigned REG_W  = 4,
  parameter int unsigned HI_REG = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src_b,
  input  logic             id_uses_b,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_wr,
  input  logic             id_wr_hi,
  input  logic             id_is_load,
  input  logic             flush,
  input  logic             freeze,
  output logic             hazard,
  output logic [2:0]       forward_sel,
  output logic             stall_if_id,
  output logic             bubble_ex
);

  localparam logic [REG_W-1:0] HiIdx = REG_W'(HI_REG);

  localparam logic [2:0] SelNone    = 3'b000;
  localparam logic [2:0] SelBtbLo   = 3'b001;
  localparam logic [2:0] SelBtbHi   = 3'b010;
  localparam logic [2:0] SelOneLo   = 3'b011;
  localparam logic [2:0] SelOneHi   = 3'b100;

  typedef enum logic {
    StRun     = 1'b0,
    StLuStall = 1'b1
  } state_e;

  state_e           state_q;

  // Shadow of the instruction currently in EX
  logic [REG_W-1:0] ex_dst_q;
  logic             ex_wr_q;
  logic             ex_hi_q;
  logic             ex_load_q;

  // Shadow of the instruction currently in MEM
  logic [REG_W-1:0] mem_dst_q;
  logic             mem_wr_q;
  logic             mem_hi_q;

  logic             hazard_q;
  logic [2:0]       forward_sel_q;

  logic             id_active;
  logic             d1lo, d1hi, d2lo, d2hi;
  logic             lu;
  logic             kill_ex;
  logic [2:0]       sel;

  assign id_active = id_valid & id_uses_b;

  assign d1lo = id_active & ex_wr_q  & (ex_dst_q  == id_src_b);
  assign d1hi = id_active & ex_hi_q  & (HiIdx     == id_src_b);
  assign d2lo = id_active & mem_wr_q & (mem_dst_q == id_src_b);
  assign d2hi = id_active & mem_hi_q & (HiIdx     == id_src_b);

  // Once the stall cycle has been spent the load sits in MEM, so lu is masked.
  assign lu = (d1lo | d1hi) & ex_load_q & (state_q == StRun);

  // Nearest producer wins; low half beats high half within a stage.
  always_comb begin
    sel = SelNone;
    if (d1lo) begin
      sel = SelBtbLo;
    end else if (d1hi) begin
      sel = SelBtbHi;
    end else if (d2lo) begin
      sel = SelOneLo;
    end else if (d2hi) begin
      sel = SelOneHi;
    end
  end

  assign kill_ex     = lu | flush;
  assign stall_if_id = lu & ~flush & ~rst;
  assign bubble_ex   = lu & ~flush & ~rst;

  assign hazard      = hazard_q;
  assign forward_sel = forward_sel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StRun;
      hazard_q      <= 1'b0;
      forward_sel_q <= SelNone;
    end else if (!freeze) begin
      if (kill_ex) begin
        hazard_q      <= 1'b0;
        forward_sel_q <= SelNone;
      end else begin
        hazard_q      <= (sel != SelNone);
        forward_sel_q <= sel;
      end

      if (flush) begin
        state_q <= StRun;
      end else begin
        case (state_q)
          StRun:     state_q <= lu ? StLuStall : StRun;
          StLuStall: state_q <= StRun;
          default:   state_q <= StRun;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_dst_q  <= '0;
      ex_wr_q   <= 1'b0;
      ex_hi_q   <= 1'b0;
      ex_load_q <= 1'b0;
      mem_dst_q <= '0;
      mem_wr_q  <= 1'b0;
      mem_hi_q  <= 1'b0;
    end else if (!freeze) begin
      mem_dst_q <= ex_dst_q;
      mem_wr_q  <= ex_wr_q;
      mem_hi_q  <= ex_hi_q;
      if (kill_ex) begin
        ex_dst_q  <= '0;
        ex_wr_q   <= 1'b0;
        ex_hi_q   <= 1'b0;
        ex_load_q <= 1'b0;
      end else begin
        ex_dst_q  <= id_dst;
        ex_wr_q   <= id_valid & id_wr;
        ex_hi_q   <= id_valid & id_wr_hi;
        ex_load_q <= id_valid & id_is_load;
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: hand-derived vector table for the directed scenarios, then
// random traffic compared against a small in-flight-instruction model.
module tb_fwd_hazard_ctrl;

  localparam int HiReg = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_src_b;
  logic       id_uses_b;
  logic [3:0] id_dst;
  logic       id_wr;
  logic       id_wr_hi;
  logic       id_is_load;
  logic       flush;
  logic       freeze;
  logic       hazard;
  logic [2:0] forward_sel;
  logic       stall_if_id;
  logic       bubble_ex;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(
    .REG_W  (4),
    .HI_REG (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_src_b    (id_src_b),
    .id_uses_b   (id_uses_b),
    .id_dst      (id_dst),
    .id_wr       (id_wr),
    .id_wr_hi    (id_wr_hi),
    .id_is_load  (id_is_load),
    .flush       (flush),
    .freeze      (freeze),
    .hazard      (hazard),
    .forward_sel (forward_sel),
    .stall_if_id (stall_if_id),
    .bubble_ex   (bubble_ex)
  );

  typedef struct {
    logic       rst;
    logic       valid;
    logic       uses_b;
    logic [3:0] src;
    logic [3:0] dst;
    logic       wr;
    logic       hi;
    logic       load;
    logic       flush;
    logic       freeze;
    logic       exp_stall;
    logic       exp_haz;
    logic [2:0] exp_sel;
  } vec_t;

  typedef struct {
    bit         wr;
    bit         hi;
    bit         load;
    logic [3:0] dst;
  } slot_t;

  vec_t  tbl[$];
  int    n_checks = 0;
  int    n_errors = 0;

  // Model: the two older in-flight instructions, plus whether the ID instruction already stalled
  slot_t m_ex, m_mem;
  bit    m_held;
  bit    m_haz;
  int    m_sel;
  bit    c_lu;
  int    c_sel;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic add(input int r, input int v, input int ub, input int src, input int dst,
                     input int wr, input int hi, input int ld, input int fl, input int fz,
                     input int es, input int eh, input int esel);
    vec_t x;
    x.rst = 1'(r);   x.valid = 1'(v);  x.uses_b = 1'(ub); x.src = 4'(src); x.dst = 4'(dst);
    x.wr = 1'(wr);   x.hi = 1'(hi);    x.load = 1'(ld);   x.flush = 1'(fl); x.freeze = 1'(fz);
    x.exp_stall = 1'(es); x.exp_haz = 1'(eh); x.exp_sel = 3'(esel);
    tbl.push_back(x);
  endtask

  task automatic model_eval();
    slot_t near[2];
    bit    act;
    bit    hit1;
    near[0] = m_ex;
    near[1] = m_mem;
    act   = id_valid && id_uses_b;
    c_sel = 0;
    for (int d = 0; d < 2; d++) begin
      if (c_sel == 0) begin
        if (act && near[d].wr && near[d].dst == id_src_b) c_sel = 2 * d + 1;
        else if (act && near[d].hi && int'(id_src_b) == HiReg) c_sel = 2 * d + 2;
      end
    end
    hit1 = (m_ex.wr && m_ex.dst == id_src_b) || (m_ex.hi && int'(id_src_b) == HiReg);
    c_lu = act && hit1 && m_ex.load && !m_held;
  endtask

  task automatic model_edge();
    bit kill;
    if (rst) begin
      m_ex = '{default: '0}; m_mem = '{default: '0};
      m_held = 0; m_haz = 0; m_sel = 0;
    end else if (!freeze) begin
      kill  = c_lu || flush;
      m_mem = m_ex;
      if (kill) m_ex = '{default: '0};
      else m_ex = '{wr: id_valid && id_wr, hi: id_valid && id_wr_hi,
                    load: id_valid && id_is_load, dst: id_dst};
      m_haz  = !kill && (c_sel != 0);
      m_sel  = kill ? 0 : c_sel;
      m_held = c_lu && !flush;
    end
  endtask

  task automatic step(input vec_t v, input bit use_tbl, input string tag);
    bit exp_st;
    @(negedge clk);
    rst = v.rst; id_valid = v.valid; id_uses_b = v.uses_b; id_src_b = v.src; id_dst = v.dst;
    id_wr = v.wr; id_wr_hi = v.hi; id_is_load = v.load; flush = v.flush; freeze = v.freeze;
    #1;
    model_eval();
    exp_st = use_tbl ? v.exp_stall : (c_lu && !flush && !rst);
    check({tag, ".stall"}, 8'(stall_if_id), 8'(exp_st));
    check({tag, ".bubble"}, 8'(bubble_ex), 8'(exp_st));
    @(posedge clk);
    model_edge();
    #1;
    if (use_tbl) begin
      check({tag, ".hazard"}, 8'(hazard), 8'(v.exp_haz));
      check({tag, ".sel"}, 8'(forward_sel), 8'(v.exp_sel));
    end else begin
      check({tag, ".hazard"}, 8'(hazard), 8'(m_haz));
      check({tag, ".sel"}, 8'(forward_sel), 8'(m_sel));
    end
  endtask

  task automatic nop();
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    vec_t rv;
    rst = 1'b1; id_valid = 0; id_src_b = 0; id_uses_b = 0; id_dst = 0; id_wr = 0;
    id_wr_hi = 0; id_is_load = 0; flush = 0; freeze = 0;
    m_ex = '{default: '0}; m_mem = '{default: '0}; m_held = 0; m_haz = 0; m_sel = 0;

    //   rst v ub src dst wr hi ld fl fz | stall haz sel
    add(1, 0, 0, 0,  0,  0, 0, 0, 0, 0,  0, 0, 0);
    add(1, 0, 0, 0,  0,  0, 0, 0, 0, 0,  0, 0, 0);
    // back-to-back ADD R3 -> consumer, then one-gap consumer
    add(0, 1, 1, 0,  3,  1, 0, 0, 0, 0,  0, 0, 0);
    add(0, 1, 1, 3,  5,  1, 0, 0, 0, 0,  0, 1, 1);
    add(0, 1, 1, 3,  6,  0, 0, 0, 0, 0,  0, 1, 3);
    nop(); nop();
    // mul writing HI: distance 1 -> 010, distance 2 -> 100, dst=R15 -> 001
    add(0, 1, 0, 0,  2,  1, 1, 0, 0, 0,  0, 0, 0);
    add(0, 1, 1, 15, 7,  0, 0, 0, 0, 0,  0, 1, 2);
    add(0, 1, 0, 0,  2,  1, 1, 0, 0, 0,  0, 0, 0);
    add(0, 1, 0, 0,  0,  0, 0, 0, 0, 0,  0, 0, 0);
    add(0, 1, 1, 15, 0,  0, 0, 0, 0, 0,  0, 1, 4);
    add(0, 1, 0, 0,  15, 1, 1, 0, 0, 0,  0, 0, 0);
    add(0, 1, 1, 15, 0,  0, 0, 0, 0, 0,  0, 1, 1);
    nop();
    // load-use: one stall, then 011, no second stall
    add(0, 1, 0, 0,  4,  1, 0, 1, 0, 0,  0, 0, 0);
    add(0, 1, 1, 4,  8,  1, 0, 0, 0, 0,  1, 0, 0);
    add(0, 1, 1, 4,  8,  1, 0, 0, 0, 0,  0, 1, 3);
    nop(); nop();
    // immediate operand and invalid ID instruction never forward
    add(0, 1, 0, 0,  3,  1, 0, 0, 0, 0,  0, 0, 0);
    add(0, 1, 0, 3,  0,  0, 0, 0, 0, 0,  0, 0, 0);
    add(0, 0, 1, 3,  0,  0, 0, 0, 0, 0,  0, 0, 0);
    nop();
    // load-use coinciding with flush: no stall, bubble into EX
    add(0, 1, 0, 0,  4,  1, 0, 1, 0, 0,  0, 0, 0);
    add(0, 1, 1, 4,  9,  1, 0, 0, 1, 0,  0, 0, 0);
    add(0, 1, 1, 4,  9,  1, 0, 0, 0, 0,  0, 1, 3);
    nop(); nop();
    // freeze in RUN with lu pending, then 3 frozen cycles in the stall state
    add(0, 1, 0, 0,  4,  1, 0, 1, 0, 0,  0, 0, 0);
    add(0, 1, 1, 4,  10, 1, 0, 0, 0, 1,  1, 0, 0);
    add(0, 1, 1, 4,  10, 1, 0, 0, 0, 0,  1, 0, 0);
    add(0, 1, 1, 4,  10, 1, 0, 0, 0, 1,  0, 0, 0);
    add(0, 1, 1, 4,  10, 1, 0, 0, 0, 1,  0, 0, 0);
    add(0, 1, 1, 4,  10, 1, 0, 0, 0, 1,  0, 0, 0);
    add(0, 1, 1, 4,  10, 1, 0, 0, 0, 0,  0, 1, 3);
    add(0, 0, 0, 0,  0,  0, 0, 0, 0, 1,  0, 1, 3);
    nop(); nop();
    // reset during the stall state, then a fresh load-use still stalls
    add(0, 1, 0, 0,  4,  1, 0, 1, 0, 0,  0, 0, 0);
    add(0, 1, 1, 4,  10, 1, 0, 0, 0, 0,  1, 0, 0);
    add(1, 1, 1, 4,  10, 1, 0, 0, 0, 0,  0, 0, 0);
    add(0, 1, 1, 4,  0,  0, 0, 0, 0, 0,  0, 0, 0);
    add(0, 1, 0, 0,  4,  1, 0, 1, 0, 0,  0, 0, 0);
    add(0, 1, 1, 4,  0,  0, 0, 0, 0, 0,  1, 0, 0);
    add(0, 1, 1, 4,  0,  0, 0, 0, 0, 0,  0, 1, 3);
    nop(); nop();
    // reset clears live forwarding outputs and shadows
    add(0, 1, 0, 0,  3,  1, 0, 0, 0, 0,  0, 0, 0);
    add(0, 1, 1, 3,  0,  0, 0, 0, 0, 0,  0, 1, 1);
    add(1, 1, 1, 3,  0,  0, 0, 0, 0, 0,  0, 0, 0);
    add(0, 1, 1, 3,  0,  0, 0, 0, 0, 0,  0, 0, 0);

    foreach (tbl[i]) step(tbl[i], 1'b1, $sformatf("vec%0d", i));

    rv = '{default: '0};
    rv.rst = 1'b1;
    step(rv, 1'b0, "rnd_rst");
    for (int i = 0; i < 400; i++) begin
      int pick[4];
      pick = '{0, 1, 2, 15};
      rv.rst    = ($urandom_range(0, 49) == 0);
      rv.valid  = ($urandom_range(0, 7) != 0);
      rv.uses_b = 1'($urandom_range(0, 1));
      rv.src    = 4'(pick[$urandom_range(0, 3)]);
      rv.dst    = 4'(pick[$urandom_range(0, 3)]);
      rv.wr     = 1'($urandom_range(0, 1));
      rv.hi     = ($urandom_range(0, 3) == 0);
      rv.load   = ($urandom_range(0, 2) == 0);
      rv.flush  = ($urandom_range(0, 9) == 0);
      rv.freeze = ($urandom_range(0, 7) == 0);
      step(rv, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
